// File: rtl/uart_ip_mm_host_initiator.sv
// UART memory-mapped host initiator: sends cmd/addr bytes, then trades one
// host byte for every slave byte and returns the collected response word.
module uart_ip_mm_host_initiator #(
    parameter int NUM_BYTES_DATA    = 4,
    parameter int NUM_BYTES_ADDRESS = 1,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_cmd,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] req_addr,
    input  logic [NUM_BYTES_DATA*8-1:0]    req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NUM_BYTES_DATA*8-1:0]    rsp_rdata,
    output logic                          rsp_err,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [7:0]                    tx_data,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          busy
);

    localparam int DW = NUM_BYTES_DATA * 8;
    localparam int AW = NUM_BYTES_ADDRESS * 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        WAIT_RX,
        SEND_DATA,
        RESP
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [TW-1:0] tmo;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          tx_xfer;
    logic          tmo_hit;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tx_xfer   = tx_valid & tx_ready;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) &&
                       (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= (req_cmd == 8'h01) || (req_cmd == 8'h02);
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        tx_data   <= req_cmd;
                        tx_valid  <= 1'b1;
                        state     <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (tx_xfer) begin
                        tx_data <= addr_q[7:0];
                        addr_q  <= addr_q >> 8;
                        cnt     <= '0;
                        state   <= SEND_ADDR;
                    end
                end
                SEND_ADDR: begin
                    if (tx_xfer) begin
                        if (cnt == 3'(NUM_BYTES_ADDRESS - 1)) begin
                            tx_valid <= 1'b0;
                            cnt      <= '0;
                            tmo      <= '0;
                            state    <= WAIT_RX;
                        end else begin
                            tx_data <= addr_q[7:0];
                            addr_q  <= addr_q >> 8;
                            cnt     <= cnt + 3'd1;
                        end
                    end
                end
                WAIT_RX: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rx_valid) begin
                        for (int i = 0; i < NUM_BYTES_DATA; i++) begin
                            if (cnt == 3'(i)) rsp_rdata[i*8 +: 8] <= rx_data;
                        end
                        tx_data  <= wr_q ? wdata_q[7:0] : 8'h00;
                        tx_valid <= 1'b1;
                        state    <= SEND_DATA;
                    end else if (tmo_hit) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                SEND_DATA: begin
                    if (tx_xfer) begin
                        tx_valid <= 1'b0;
                        wdata_q  <= wdata_q >> 8;
                        if (cnt == 3'(NUM_BYTES_DATA - 1)) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            cnt   <= cnt + 3'd1;
                            tmo   <= '0;
                            state <= WAIT_RX;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ip_mm_host_initiator.sv
// Scoreboard bench for the UART host initiator: directed transactions with a
// slave model; a negedge monitor checks TX bytes and responses from queues.
module tb_uart_ip_mm_host_initiator;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  tx_q[$];
    logic [32:0] rsp_q[$];
    bit          mon_en = 1'b1;

    uart_ip_mm_host_initiator #(
        .NUM_BYTES_DATA   (4),
        .NUM_BYTES_ADDRESS(1),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change at posedge+1, so a negedge sample predicts
    // the handshakes that complete at the following posedge.
    int         hdr;
    int         rx_cnt;
    int         dat_cnt;
    bit         stalled_prev = 1'b0;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (!arst_n || !mon_en) begin
            stalled_prev = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                hdr = 0; rx_cnt = 0; dat_cnt = 0;
            end
            if (rx_valid && hdr >= 2) rx_cnt++;
            if (stalled_prev && tx_valid)
                check("tx_stable", 64'(tx_data), 64'(prev_data));
            stalled_prev = tx_valid && !tx_ready;
            prev_data    = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL tx_extra: got %0h expected none", tx_data);
                end else begin
                    check("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
                end
                if (hdr >= 2) begin
                    check("data_after_rx", 64'(rx_cnt > dat_cnt), 64'(1));
                    dat_cnt++;
                end else begin
                    hdr++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_extra: got %0h expected none", rsp_rdata);
                end else begin
                    check("rsp", 64'({rsp_err, rsp_rdata}), 64'(rsp_q.pop_front()));
                end
            end
        end
    end

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [31:0] rxw,
                           input int n_rx, input int stall, input int hold,
                           input bit stray);
        bit          wr, wx, whs, done, seen;
        int          n_xfer, wait_cnt, since, hcnt;
        logic [31:0] exp_rd, first_rd;
        wr     = (cmd == 8'h01) || (cmd == 8'h02);
        exp_rd = '0;
        tx_q.push_back(cmd);
        tx_q.push_back(addr);
        for (int i = 0; i < n_rx; i++) begin
            tx_q.push_back(wr ? wd[8*i +: 8] : 8'h00);
            exp_rd[8*i +: 8] = rxw[8*i +: 8];
        end
        rsp_q.push_back({n_rx < 4, exp_rd});
        @(posedge clk); #1;
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_cmd = 8'hA5; req_addr = ~addr; req_wdata = ~wd;
        check("first_tx_valid", 64'(tx_valid), 64'(1));
        wx = 0; whs = 0; done = 0; seen = 0; first_rd = '0;
        n_xfer = 0; wait_cnt = 0; since = 0; hcnt = 0;
        for (int it = 0; it < 400 && !done; it++) begin
            rx_valid = 1'b0;
            since++;
            if (wx) begin
                n_xfer++; wait_cnt = 0; since = 0;
                if (stray && n_xfer == 1) begin
                    rx_valid = 1'b1; rx_data = 8'hEE;
                end
                if (n_xfer >= 2 && n_xfer - 2 < n_rx) begin
                    rx_valid = 1'b1; rx_data = rxw[8*(n_xfer-2) +: 8];
                end
            end
            if (whs) begin
                done = 1; rsp_ready = 1'b0;
                check("idle_after_rsp", 64'(busy), 64'(0));
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; first_rd = rsp_rdata;
                    check("rsp_latency", 64'(since), 64'(n_rx < 4 ? TMO : 0));
                end else begin
                    check("rsp_hold", 64'({rsp_rdata, req_ready}),
                          64'({first_rd, 1'b0}));
                end
                rsp_ready = (hcnt >= hold);
                hcnt++;
            end
            if (stall == 0) tx_ready = 1'b1;
            else if (tx_valid) begin
                tx_ready = (wait_cnt >= stall);
                if (!tx_ready) wait_cnt++;
            end else tx_ready = 1'b0;
            wx  = tx_valid && tx_ready;
            whs = rsp_valid && rsp_ready;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL txn_budget: got no response expected response");
        end
        rx_valid = 1'b0; rsp_ready = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = '0;
        #12;
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        @(posedge clk); #1; arst_n = 1'b1;

        run_txn(8'h01, 8'h2A, 32'hDEADBEEF, 32'h44332211, 4, 0, 0, 0);
        run_txn(8'h00, 8'h05, 32'h0, 32'h12345678, 4, 0, 0, 0);
        run_txn(8'h01, 8'h2A, 32'hDEADBEEF, 32'h44332211, 4, 7, 0, 0);
        run_txn(8'h02, 8'h33, 32'hCAFEF00D, 32'h7766BBAA, 2, 0, 0, 0);
        run_txn(8'h03, 8'h7E, 32'h55555555, 32'h9ABCDEF0, 4, 0, 5, 1);
        run_txn(8'h5A, 8'h01, 32'h01020304, 32'hA1B2C3D4, 4, 2, 1, 0);

        mon_en = 1'b0;
        @(posedge clk); #1;
        tx_ready = 1'b1; req_valid = 1'b1; req_cmd = 8'h01;
        req_addr = 8'h10; req_wdata = 32'h01020304;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h99; tx_ready = 1'b0;
        @(posedge clk); #1; rx_valid = 1'b0;
        check("pre_rst_send_data", 64'({tx_valid, tx_data}), 64'({1'b1, 8'h04}));
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rdata", 64'(rsp_rdata), 64'(0));
        @(posedge clk); #1; arst_n = 1'b1; mon_en = 1'b1;

        run_txn(8'h00, 8'h44, 32'h0, 32'h0BADC0DE, 4, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("tx_q_drained", 64'(tx_q.size()), 64'(0));
        check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
